// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared constants for the RV32I ID-stage hazard scoreboard:
//   - major opcode encodings the hazard logic cares about
//   - bit positions of the rd / rs1 / rs2 / opcode fields
//   - helper functions that slice those fields out of an instruction word
// No ports (package).
// -----------------------------------------------------------------------------
package hazard_pkg;

   // Architectural register index width (RV32I register file is x0..x31)
   localparam int REG_W = 5;

   typedef logic [REG_W-1:0] reg_idx_t;
   typedef logic [6:0]       opcode_t;

   // Major opcodes
   localparam opcode_t OP_LOAD   = 7'b0000011;
   localparam opcode_t OP_STORE  = 7'b0100011;
   localparam opcode_t OP_BRANCH = 7'b1100011;
   localparam opcode_t OP_OP     = 7'b0110011;
   localparam opcode_t OP_IMM    = 7'b0010011;
   localparam opcode_t OP_LUI    = 7'b0110111;
   localparam opcode_t OP_AUIPC  = 7'b0010111;
   localparam opcode_t OP_JAL    = 7'b1101111;
   localparam opcode_t OP_JALR   = 7'b1100111;

   // Field slice positions
   localparam int OPC_LSB = 0;
   localparam int OPC_MSB = 6;
   localparam int RD_LSB  = 7;
   localparam int RD_MSB  = 11;
   localparam int RS1_LSB = 15;
   localparam int RS1_MSB = 19;
   localparam int RS2_LSB = 20;
   localparam int RS2_MSB = 24;

   function automatic opcode_t get_opcode(input logic [31:0] instr);
      return instr[OPC_MSB:OPC_LSB];
   endfunction

   function automatic reg_idx_t get_rd(input logic [31:0] instr);
      return instr[RD_MSB:RD_LSB];
   endfunction

   function automatic reg_idx_t get_rs1(input logic [31:0] instr);
      return instr[RS1_MSB:RS1_LSB];
   endfunction

   function automatic reg_idx_t get_rs2(input logic [31:0] instr);
      return instr[RS2_MSB:RS2_LSB];
   endfunction

endpackage : hazard_pkg

// File: rtl/hazard_decode.sv
// -----------------------------------------------------------------------------
// hazard_decode
// Purely combinational register-usage decode of the instruction in IF/ID.
// Only the fields that matter for hazard detection are extracted.
// Ports:
//   id_instr_i   in  32  instruction word
//   rs1_o        out 5   rs1 field
//   rs2_o        out 5   rs2 field
//   rd_o         out 5   rd field
//   use_rs1_o    out 1   instruction reads rs1
//   use_rs2_o    out 1   instruction reads rs2
//   wr_rd_o      out 1   instruction writes a nonzero rd
//   is_load_o    out 1   LOAD class (long producer latency)
//   is_branch_o  out 1   conditional branch (resolves in ID, needs final value)
// -----------------------------------------------------------------------------
module hazard_decode
   import hazard_pkg::*;
(
   input  logic [31:0]      id_instr_i,
   output logic [REG_W-1:0] rs1_o,
   output logic [REG_W-1:0] rs2_o,
   output logic [REG_W-1:0] rd_o,
   output logic             use_rs1_o,
   output logic             use_rs2_o,
   output logic             wr_rd_o,
   output logic             is_load_o,
   output logic             is_branch_o
);

   opcode_t  opcode;
   reg_idx_t rd_field;
   logic     writes_rd;

   // funct3/funct7/immediate bits carry no register-usage information
   logic unused_bits;
   assign unused_bits = ^{id_instr_i[31:25], id_instr_i[14:12]};

   always_comb begin
      opcode      = get_opcode(id_instr_i);
      rd_field    = get_rd(id_instr_i);
      rs1_o       = get_rs1(id_instr_i);
      rs2_o       = get_rs2(id_instr_i);
      rd_o        = rd_field;
      use_rs1_o   = 1'b0;
      use_rs2_o   = 1'b0;
      writes_rd   = 1'b0;
      is_load_o   = 1'b0;
      is_branch_o = 1'b0;

      case (opcode)
         OP_LOAD: begin
            use_rs1_o = 1'b1;
            writes_rd = 1'b1;
            is_load_o = 1'b1;
         end
         OP_STORE: begin
            use_rs1_o = 1'b1;
            use_rs2_o = 1'b1;
         end
         OP_BRANCH: begin
            use_rs1_o   = 1'b1;
            use_rs2_o   = 1'b1;
            is_branch_o = 1'b1;
         end
         OP_OP: begin
            use_rs1_o = 1'b1;
            use_rs2_o = 1'b1;
            writes_rd = 1'b1;
         end
         OP_IMM, OP_JALR: begin
            use_rs1_o = 1'b1;
            writes_rd = 1'b1;
         end
         OP_LUI, OP_AUIPC, OP_JAL: begin
            writes_rd = 1'b1;
         end
         default: begin
         end
      endcase

      // Writes to x0 are architecturally discarded, so they never create a hazard
      wr_rd_o = writes_rd && (rd_field != '0);
   end

endmodule : hazard_decode

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Load/ALU hazard unit beside the ID stage of the in-order RV32I pipeline.
// Each tracked register has a small countdown of cycles until its in-flight
// result can be forwarded into ID. ID is stalled until every source operand
// is obtainable: branches (resolved in ID) need the counter at 0, all other
// consumers can take an EX-stage forward and accept a counter of 1.
// A flush squashes the write of the instruction issued in the previous cycle.
// A watchdog flags runs of MAX_STALL consecutive stall cycles (sticky).
//
// Optional feature macro: HAZ_PERF_CNT_EN
//   defined   -> stall_cnt_o counts stall cycles (32-bit, wrapping)
//   undefined -> stall_cnt_o is tied to 0 and the counter is absent
//
// Parameters:
//   NREG       architectural registers (<= 32); x0 is never tracked
//   LOAD_LAT   cycles after issue until a load result reaches ID (1..7)
//   ALU_LAT    cycles after issue until an ALU result reaches ID (0..LOAD_LAT)
//   MAX_STALL  consecutive stall cycles that raise err_stall_o (>= 1)
// Ports:
//   clk_i        in  1   rising-edge clock
//   rst_i        in  1   synchronous active-high reset
//   id_valid_i   in  1   id_instr_i holds a live instruction
//   id_instr_i   in  32  instruction in IF/ID
//   flush_i      in  1   kill the ID instruction and the one issued last cycle
//   id_stall_o   out 1   hold PC and IF/ID, bubble into ID/EX
//   id_issue_o   out 1   the ID instruction advances this cycle
//   err_stall_o  out 1   sticky watchdog error
//   stall_cnt_o  out 32  total stall cycles (feature build only)
// -----------------------------------------------------------------------------
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NREG      = 32,
   parameter int LOAD_LAT  = 2,
   parameter int ALU_LAT   = 1,
   parameter int MAX_STALL = 15
)
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        id_valid_i,
   input  logic [31:0] id_instr_i,
   input  logic        flush_i,
   output logic        id_stall_o,
   output logic        id_issue_o,
   output logic        err_stall_o,
   output logic [31:0] stall_cnt_o
);

   localparam int CW    = $clog2(LOAD_LAT + 1);
   localparam int RUN_W = $clog2(MAX_STALL + 1);

   localparam logic [CW-1:0]    LOAD_INIT = CW'(LOAD_LAT);
   localparam logic [CW-1:0]    ALU_INIT  = CW'(ALU_LAT);
   localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(MAX_STALL);

   // ---------------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------------
   reg_idx_t rs1;
   reg_idx_t rs2;
   reg_idx_t rd;
   logic     use_rs1;
   logic     use_rs2;
   logic     wr_rd;
   logic     is_load;
   logic     is_branch;

   hazard_decode u_decode (
      .id_instr_i  (id_instr_i),
      .rs1_o       (rs1),
      .rs2_o       (rs2),
      .rd_o        (rd),
      .use_rs1_o   (use_rs1),
      .use_rs2_o   (use_rs2),
      .wr_rd_o     (wr_rd),
      .is_load_o   (is_load),
      .is_branch_o (is_branch)
   );

   // ---------------------------------------------------------------------
   // Control
   // ---------------------------------------------------------------------
   logic [NREG-1:0] haz_vec;
   logic            hazard;
   logic            issue_wr;
   reg_idx_t        last_rd_q;
   reg_idx_t        last_rd_d;

   assign hazard     = |haz_vec;
   assign id_stall_o = id_valid_i && hazard && !flush_i;
   assign id_issue_o = id_valid_i && !hazard && !flush_i;
   assign issue_wr   = id_issue_o && wr_rd;

   // Remember which register the just-issued instruction will write, so a
   // flush in the next cycle can cancel that write. Zero means "nothing".
   assign last_rd_d = issue_wr ? rd : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_rd_q <= '0;
      end else begin
         last_rd_q <= last_rd_d;
      end
   end

   // ---------------------------------------------------------------------
   // Per-register countdown scoreboard
   // ---------------------------------------------------------------------
   for (genvar gi = 0; gi < NREG; gi++) begin : g_ent
      if (gi == 0) begin : g_x0
         // x0 reads as constant zero and can never be pending
         assign haz_vec[gi] = 1'b0;
      end else begin : g_trk
         logic [CW-1:0] cnt_q;
         logic [CW-1:0] cnt_d;
         logic          src_hit;
         logic          not_ready;

         assign src_hit = (use_rs1 && (rs1 == REG_W'(gi))) ||
                          (use_rs2 && (rs2 == REG_W'(gi)));

         // Branches compare in ID and need the value already written back;
         // everyone else can pick it up from EX once the count reaches 1.
         assign not_ready = is_branch ? (cnt_q != '0) : (cnt_q > CW'(1));

         assign haz_vec[gi] = src_hit && not_ready;

         always_comb begin
            cnt_d = (cnt_q != '0) ? (cnt_q - CW'(1)) : '0;
            if (flush_i && (last_rd_q == REG_W'(gi))) begin
               // wrong-path producer: its result will never arrive
               cnt_d = '0;
            end else if (issue_wr && (rd == REG_W'(gi))) begin
               // a fresh issue overrides this cycle's decrement
               cnt_d = is_load ? LOAD_INIT : ALU_INIT;
            end
         end

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stall watchdog
   // ---------------------------------------------------------------------
   logic [RUN_W-1:0] run_q;
   logic [RUN_W-1:0] run_d;
   logic             err_q;
   logic             err_d;

   always_comb begin
      run_d = '0;
      if (id_stall_o) begin
         run_d = (run_q == RUN_MAX) ? run_q : (run_q + RUN_W'(1));
      end
      // flag as soon as the run reaches the limit, so the error is visible
      // during the stall cycle that follows the MAX_STALL-th one
      err_d = err_q || (id_stall_o && (run_d == RUN_MAX));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         run_q <= '0;
         err_q <= 1'b0;
      end else begin
         run_q <= run_d;
         err_q <= err_d;
      end
   end

   assign err_stall_o = err_q;

   // ---------------------------------------------------------------------
   // Optional stall performance counter
   // ---------------------------------------------------------------------
`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] stall_cnt_d;

   assign stall_cnt_d = id_stall_o ? (stall_cnt_q + 32'd1) : stall_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   assign stall_cnt_o = '0;
`endif

endmodule : hazard_scoreboard

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
// Two instances share the stimulus: u_dut with default parameters and u_wd
// with LOAD_LAT=3 / MAX_STALL=2 for the watchdog. Expected outputs are queued
// when a cycle is driven and popped when the DUT is sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

`ifdef HAZ_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   localparam logic [6:0] O_LOAD   = 7'b0000011;
   localparam logic [6:0] O_BRANCH = 7'b1100011;
   localparam logic [6:0] O_OP     = 7'b0110011;
   localparam logic [6:0] O_IMM    = 7'b0010011;

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic [31:0] id_instr;
   logic        flush;

   logic        stall0, issue0, err0;
   logic [31:0] cnt0;
   logic        stall1, issue1, err1;
   logic [31:0] cnt1;

   int n_vec;
   int n_err;
   int exp_scnt;

   typedef struct {
      logic  stall;
      logic  issue;
      logic  err;
      logic [31:0] scnt;
      bit    sel;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];

   hazard_scoreboard u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .id_valid_i  (id_valid),
      .id_instr_i  (id_instr),
      .flush_i     (flush),
      .id_stall_o  (stall0),
      .id_issue_o  (issue0),
      .err_stall_o (err0),
      .stall_cnt_o (cnt0)
   );

   hazard_scoreboard #(
      .LOAD_LAT  (3),
      .ALU_LAT   (1),
      .MAX_STALL (2)
   ) u_wd (
      .clk_i       (clk),
      .rst_i       (rst),
      .id_valid_i  (id_valid),
      .id_instr_i  (id_instr),
      .flush_i     (flush),
      .id_stall_o  (stall1),
      .id_issue_o  (issue1),
      .err_stall_o (err1),
      .stall_cnt_o (cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'd0, rs2, rs1, 3'd0, rd, op};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Pop one expectation and compare it against the selected instance
   task automatic score();
      exp_t  e;
      string t;
      if (exp_q.size() == 0) begin
         check_eq("queue_empty", 32'd1, 32'd0);
         return;
      end
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (e.sel) begin
         check_eq({t, ".stall"}, {31'd0, stall1}, {31'd0, e.stall});
         check_eq({t, ".issue"}, {31'd0, issue1}, {31'd0, e.issue});
         check_eq({t, ".err"},   {31'd0, err1},   {31'd0, e.err});
      end else begin
         check_eq({t, ".stall"}, {31'd0, stall0}, {31'd0, e.stall});
         check_eq({t, ".issue"}, {31'd0, issue0}, {31'd0, e.issue});
         check_eq({t, ".err"},   {31'd0, err0},   {31'd0, e.err});
         check_eq({t, ".cnt"},   cnt0,            e.scnt);
      end
      $display("vec %-14s sel=%0d stall=%0d/%0d issue=%0d/%0d err=%0d/%0d",
               t, e.sel, e.sel ? stall1 : stall0, e.stall,
               e.sel ? issue1 : issue0, e.issue, e.sel ? err1 : err0, e.err);
   endtask

   // One clock cycle: drive at posedge+1, check at negedge
   task automatic step(input bit sel, input string tag, input logic v, input logic [31:0] ins,
                       input logic fl, input logic es, input logic ei, input logic ee);
      exp_t e;
      id_valid = v;
      id_instr = ins;
      flush    = fl;
      e.stall  = es;
      e.issue  = ei;
      e.err    = ee;
      e.sel    = sel;
      e.scnt   = PERF ? 32'(exp_scnt) : 32'd0;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
      score();
      if (es && !sel) exp_scnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_scnt = 0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      logic [31:0] lw5, beq5, add6, add7, addi10, add11, addi3, bne3, addi0, bne0;
      logic [31:0] lw8, beq8, lw12, beq12, lw13, beq13;
      n_vec = 0;
      n_err = 0;
      exp_scnt = 0;
      lw5    = mk(O_LOAD,   5'd5,  5'd1,  5'd0);
      beq5   = mk(O_BRANCH, 5'd0,  5'd5,  5'd0);
      add6   = mk(O_OP,     5'd6,  5'd5,  5'd1);
      add7   = mk(O_OP,     5'd7,  5'd1,  5'd2);
      addi10 = mk(O_IMM,    5'd10, 5'd1,  5'd0);
      add11  = mk(O_OP,     5'd11, 5'd10, 5'd0);
      addi3  = mk(O_IMM,    5'd3,  5'd1,  5'd0);
      bne3   = mk(O_BRANCH, 5'd0,  5'd3,  5'd4);
      addi0  = mk(O_IMM,    5'd0,  5'd1,  5'd0);
      bne0   = mk(O_BRANCH, 5'd0,  5'd0,  5'd4);
      lw8    = mk(O_LOAD,   5'd8,  5'd1,  5'd0);
      beq8   = mk(O_BRANCH, 5'd0,  5'd8,  5'd0);
      lw12   = mk(O_LOAD,   5'd12, 5'd1,  5'd0);
      beq12  = mk(O_BRANCH, 5'd0,  5'd12, 5'd0);
      lw13   = mk(O_LOAD,   5'd13, 5'd1,  5'd0);
      beq13  = mk(O_BRANCH, 5'd0,  5'd13, 5'd0);

      rst = 1'b1;
      id_valid = 1'b0;
      id_instr = '0;
      flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state
      step(0, "rst_idle", 0, '0, 0, 0, 0, 0);
      step(1, "rst_idle_wd", 0, '0, 0, 0, 0, 0);

      // load then branch: two stall cycles
      step(0, "t1_lw",     1, lw5,  0, 0, 1, 0);
      step(0, "t1_beq_s1", 1, beq5, 0, 1, 0, 0);
      step(0, "t1_beq_s2", 1, beq5, 0, 1, 0, 0);
      step(0, "t1_beq_go", 1, beq5, 0, 0, 1, 0);

      // load then ALU consumer: one stall, independent ALU op: none
      step(0, "t2_lw",     1, lw5,  0, 0, 1, 0);
      step(0, "t2_add_s1", 1, add6, 0, 1, 0, 0);
      step(0, "t2_add_go", 1, add6, 0, 0, 1, 0);
      step(0, "t2_add7",   1, add7, 0, 0, 1, 0);
      check_eq("t6_cnt3", cnt0, PERF ? 32'd3 : 32'd0);

      // ALU to ALU back-to-back is covered by EX forwarding
      step(0, "fw_addi",   1, addi10, 0, 0, 1, 0);
      step(0, "fw_add",    1, add11,  0, 0, 1, 0);

      // ALU producer then branch: one stall; rd=x0 producer: none
      step(0, "t3_addi",   1, addi3, 0, 0, 1, 0);
      step(0, "t3_bne_s1", 1, bne3,  0, 1, 0, 0);
      step(0, "t3_bne_go", 1, bne3,  0, 0, 1, 0);
      step(0, "t3_addi0",  1, addi0, 0, 0, 1, 0);
      step(0, "t3_bne0",   1, bne0,  0, 0, 1, 0);

      // flush squashes the just-issued load
      step(0, "t4_lw",     1, lw8,  0, 0, 1, 0);
      step(0, "t4_flush",  1, beq8, 1, 0, 0, 0);
      step(0, "t4_beq",    1, beq8, 0, 0, 1, 0);
      step(0, "t4_flush0", 1, beq8, 1, 0, 0, 0);
      step(0, "t4_after",  1, add7, 0, 0, 1, 0);

      // invalid ID slot never stalls even with a pending hazard
      step(0, "iv_lw",     1, lw12,  0, 0, 1, 0);
      step(0, "iv_idle",   0, beq12, 0, 0, 0, 0);
      step(0, "iv_beq_s1", 1, beq12, 0, 1, 0, 0);
      step(0, "iv_beq_go", 1, beq12, 0, 0, 1, 0);

      // reset asserted mid-stall
      step(0, "t6_lw",     1, lw13,  0, 0, 1, 0);
      step(0, "t6_beq_s1", 1, beq13, 0, 1, 0, 0);
      pulse_rst();
      step(0, "t6_postrst", 1, beq13, 0, 0, 1, 0);

      // watchdog on the LOAD_LAT=3 / MAX_STALL=2 instance
      pulse_rst();
      step(1, "wd_lw",     1, lw5,  0, 0, 1, 0);
      step(1, "wd_s1",     1, beq5, 0, 1, 0, 0);
      step(1, "wd_s2",     1, beq5, 0, 1, 0, 0);
      step(1, "wd_s3",     1, beq5, 0, 1, 0, 1);
      step(1, "wd_go",     1, beq5, 0, 0, 1, 1);
      step(1, "wd_hold",   0, '0,   0, 0, 0, 1);
      step(1, "wd_hold2",  1, add7, 0, 0, 1, 1);
      pulse_rst();
      step(1, "wd_cleared", 0, '0,  0, 0, 0, 0);

      if (exp_q.size() != 0) check_eq("queue_leftover", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_hazard_scoreboard
